// File: rtl/pll_lock_phase_ctrl.sv
// rtl/pll_lock_phase_ctrl.sv - rPLL reset/lock supervisor with PSDA dynamic phase stepping
module pll_lock_phase_ctrl #(
    parameter int                    PHASE_BITS    = 4,
    parameter logic [PHASE_BITS-1:0] PHASE_INIT    = 4'b1000,
    parameter int                    RESET_CYCLES  = 16,
    parameter int                    LOCK_STABLE   = 256,
    parameter int                    LOCK_TIMEOUT  = 65536,
    parameter int                    SETTLE_CYCLES = 64,
    parameter int                    MAX_RETRY     = 3
) (
    input  logic                  clkin,
    input  logic                  reset,
    input  logic                  pll_lock,
    output logic                  pll_reset,
    output logic [PHASE_BITS-1:0] psda,
    output logic                  rst_out,
    output logic                  ready,
    output logic                  fault,
    output logic [1:0]            retries,
    input  logic                  ph_req,
    input  logic [PHASE_BITS-1:0] ph_val,
    output logic                  ph_ack,
    output logic                  ph_nak
);

    localparam int MAX_A   = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CYC = (MAX_A > SETTLE_CYCLES) ? MAX_A : SETTLE_CYCLES;
    localparam int CW      = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] RST_LAST     = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_TGT   = CW'(LOCK_STABLE);
    localparam logic [1:0]    RETRY_MAX    = 2'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_RST_PLL,
        ST_WAIT_LOCK,
        ST_LOCKED,
        ST_SETTLE,
        ST_FAULT
    } state_t;

    state_t                state_q;
    logic                  sync_q;
    logic                  lock_s_q;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         stable_q;
    logic                  pll_reset_q;
    logic                  rst_out_q;
    logic [PHASE_BITS-1:0] psda_q;
    logic                  ready_q;
    logic                  fault_q;
    logic [1:0]            retries_q;
    logic                  ph_ack_q;
    logic                  ph_nak_q;

    logic [CW-1:0]         cnt_d;
    logic [CW-1:0]         stable_d;
    logic [1:0]            retries_d;

    always_comb begin
        cnt_d     = cnt_q + CW'(1);
        stable_d  = lock_s_q ? (stable_q + CW'(1)) : '0;
        retries_d = retries_q + 2'd1;
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q     <= ST_RST_PLL;
            sync_q      <= 1'b0;
            lock_s_q    <= 1'b0;
            cnt_q       <= '0;
            stable_q    <= '0;
            pll_reset_q <= 1'b1;
            rst_out_q   <= 1'b1;
            psda_q      <= PHASE_INIT;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
            retries_q   <= 2'd0;
            ph_ack_q    <= 1'b0;
            ph_nak_q    <= 1'b0;
        end else begin
            // LOCK is asynchronous to clkin; only lock_s_q is used by the FSM
            sync_q   <= pll_lock;
            lock_s_q <= sync_q;
            ph_ack_q <= 1'b0;
            ph_nak_q <= 1'b0;

            case (state_q)
                ST_RST_PLL: begin
                    pll_reset_q <= 1'b1;
                    rst_out_q   <= 1'b1;
                    ready_q     <= 1'b0;
                    stable_q    <= '0;
                    if (cnt_q == RST_LAST) begin
                        cnt_q       <= '0;
                        pll_reset_q <= 1'b0;
                        state_q     <= ST_WAIT_LOCK;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                ST_WAIT_LOCK: begin
                    cnt_q    <= cnt_d;
                    stable_q <= stable_d;
                    // A lock qualifying on the last allowed cycle still wins over the timeout
                    if (stable_d == STABLE_TGT) begin
                        state_q   <= ST_LOCKED;
                        ready_q   <= 1'b1;
                        rst_out_q <= 1'b0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        retries_q   <= retries_d;
                        cnt_q       <= '0;
                        pll_reset_q <= 1'b1;
                        if (retries_d == RETRY_MAX) begin
                            state_q <= ST_FAULT;
                            fault_q <= 1'b1;
                        end else begin
                            state_q <= ST_RST_PLL;
                        end
                    end
                end

                ST_LOCKED: begin
                    if (!lock_s_q) begin
                        state_q     <= ST_RST_PLL;
                        pll_reset_q <= 1'b1;
                        rst_out_q   <= 1'b1;
                        ready_q     <= 1'b0;
                        retries_q   <= 2'd0;
                        cnt_q       <= '0;
                    end else if (ph_req) begin
                        psda_q  <= ph_val;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        state_q <= ST_SETTLE;
                    end
                end

                ST_SETTLE: begin
                    // Output domains keep running; only a lock loss restarts the PLL
                    if (!lock_s_q) begin
                        ph_nak_q    <= 1'b1;
                        state_q     <= ST_RST_PLL;
                        pll_reset_q <= 1'b1;
                        rst_out_q   <= 1'b1;
                        retries_q   <= 2'd0;
                        cnt_q       <= '0;
                    end else if (cnt_q == SETTLE_LAST) begin
                        ph_ack_q <= 1'b1;
                        ready_q  <= 1'b1;
                        state_q  <= ST_LOCKED;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                ST_FAULT: begin
                    pll_reset_q <= 1'b1;
                    rst_out_q   <= 1'b1;
                    ready_q     <= 1'b0;
                    fault_q     <= 1'b1;
                end

                default: begin
                    state_q     <= ST_RST_PLL;
                    pll_reset_q <= 1'b1;
                    rst_out_q   <= 1'b1;
                    ready_q     <= 1'b0;
                    cnt_q       <= '0;
                end
            endcase
        end
    end

    assign pll_reset = pll_reset_q;
    assign psda      = psda_q;
    assign rst_out   = rst_out_q;
    assign ready     = ready_q;
    assign fault     = fault_q;
    assign retries   = retries_q;
    assign ph_ack    = ph_ack_q;
    assign ph_nak    = ph_nak_q;

endmodule

// File: tb/tb_pll_lock_phase_ctrl.sv
// tb/tb_pll_lock_phase_ctrl.sv - self-checking bench for pll_lock_phase_ctrl
module tb_pll_lock_phase_ctrl;

    localparam int RC = 4;
    localparam int LS = 8;
    localparam int LT = 64;
    localparam int SC = 16;
    localparam int MR = 3;
    localparam int WIN = 24;
    localparam logic [3:0] P_INIT = 4'b1000;

    logic       clk = 1'b0;
    logic       reset;
    logic       pll_lock;
    logic       pll_reset;
    logic [3:0] psda;
    logic       rst_out;
    logic       ready;
    logic       fault;
    logic [1:0] retries;
    logic       ph_req;
    logic [3:0] ph_val;
    logic       ph_ack;
    logic       ph_nak;

    int n_tests = 0;
    int n_fail  = 0;

    pll_lock_phase_ctrl #(
        .PHASE_BITS   (4),
        .PHASE_INIT   (P_INIT),
        .RESET_CYCLES (RC),
        .LOCK_STABLE  (LS),
        .LOCK_TIMEOUT (LT),
        .SETTLE_CYCLES(SC),
        .MAX_RETRY    (MR)
    ) dut (
        .clkin    (clk),
        .reset    (reset),
        .pll_lock (pll_lock),
        .pll_reset(pll_reset),
        .psda     (psda),
        .rst_out  (rst_out),
        .ready    (ready),
        .fault    (fault),
        .retries  (retries),
        .ph_req   (ph_req),
        .ph_val   (ph_val),
        .ph_ack   (ph_ack),
        .ph_nak   (ph_nak)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        pll_lock = 1'b0;
        ph_req   = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // Samples spent with pll_reset high, starting from the current sample
    task automatic wait_reset_fall(output int n);
        n = 0;
        while (pll_reset === 1'b1 && n < 200) begin
            n++;
            tick();
        end
    endtask

    // Raise pll_lock after d cycles; return cycles until ready
    task automatic lock_after(input int d, output int n);
        repeat (d) tick();
        pll_lock = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    // Phase step with an optional lock drop drop_at cycles into settle; expectations from the model
    task automatic run_step(input logic [3:0] val, input int drop_at);
        int         resp_i;
        int         acks;
        int         naks;
        int         rst_pre;
        int         prh;
        int         n;
        logic       ready_resp;
        logic       rst_resp;
        logic [3:0] psda_s0;
        resp_i = -1; acks = 0; naks = 0; rst_pre = 0; prh = 0;
        ready_resp = 1'b0; rst_resp = 1'b0;
        ph_val = val;
        ph_req = 1'b1;
        tick();
        psda_s0 = psda;
        check("step_ready_drop", ready, 0);
        for (int i = 0; i < WIN; i++) begin
            if (i > 0) tick();
            if (resp_i < 0) begin
                if (ph_ack === 1'b1 || ph_nak === 1'b1) begin
                    resp_i     = i;
                    ready_resp = ready;
                    rst_resp   = rst_out;
                    ph_req     = 1'b0;
                end else if (rst_out !== 1'b0) begin
                    rst_pre++;
                end
            end
            if (ph_ack === 1'b1) acks++;
            if (ph_nak === 1'b1) naks++;
            if (resp_i >= 0 && pll_reset === 1'b1) prh++;
            if (i == drop_at) pll_lock = 1'b0;
        end
        ph_req = 1'b0;
        check("step_psda_applied", psda_s0, val);
        check("step_psda_end", psda, val);
        check("step_rst_out_in_settle", rst_pre, 0);
        if (drop_at < 0) begin
            check("step_ack_cycle", resp_i, SC);
            check("step_ack_count", acks, 1);
            check("step_nak_count", naks, 0);
            check("step_ready_with_ack", ready_resp, 1);
            check("step_rst_out_with_ack", rst_resp, 0);
            check("step_pll_reset_after_ack", prh, 0);
        end else begin
            check("step_nak_cycle", resp_i, drop_at + 3);
            check("step_ack_count", acks, 0);
            check("step_nak_count", naks, 1);
            check("step_ready_with_nak", ready_resp, 0);
            check("step_rst_out_with_nak", rst_resp, 1);
            check("step_pll_reset_width", prh, RC);
            lock_after($urandom_range(0, 20), n);
            check("step_relock_latency", n, 2 + LS);
            check("step_relock_retries", retries, 0);
            check("step_relock_rst_out", rst_out, 0);
        end
    endtask

    initial begin
        int n;
        int c;
        int t1;
        int t2;
        int bad;
        int pulses;
        logic [3:0] v;

        reset    = 1'b1;
        pll_lock = 1'b0;
        ph_req   = 1'b0;
        ph_val   = 4'd0;
        tick();
        tick();
        check("rst_pll_reset", pll_reset, 1);
        check("rst_rst_out", rst_out, 1);
        check("rst_psda", psda, P_INIT);
        check("rst_ready", ready, 0);
        check("rst_fault", fault, 0);
        check("rst_retries", retries, 0);
        check("rst_ph_ack", ph_ack, 0);
        check("rst_ph_nak", ph_nak, 0);

        // Normal lock
        reset = 1'b0;
        wait_reset_fall(n);
        check("t1_pll_reset_width", n, RC);
        lock_after(10, n);
        check("t1_release_latency", n, 2 + LS);
        check("t1_rst_out_low", rst_out, 0);
        check("t1_psda", psda, P_INIT);
        check("t1_retries", retries, 0);

        // Glitchy lock restarts the stable count
        do_reset();
        wait_reset_fall(n);
        check("t2_pll_reset_width", n, RC);
        repeat (3) tick();
        pll_lock = 1'b1;
        repeat (5) tick();
        pll_lock = 1'b0;
        tick();
        check("t2_no_early_ready", ready, 0);
        lock_after(0, n);
        check("t2_release_after_final_rise", n, 2 + LS);

        // Timeout, retries and fault
        do_reset();
        c = 0; t1 = -1; t2 = -1;
        while (fault !== 1'b1 && c < 400) begin
            tick();
            c++;
            if (retries === 2'd1 && t1 < 0) t1 = c;
            if (retries === 2'd2 && t2 < 0) t2 = c;
        end
        check("t3_retry1_cycle", t1, RC + LT);
        check("t3_retry2_cycle", t2, 2 * (RC + LT));
        check("t3_fault_cycle", c, MR * (RC + LT));
        check("t3_retries_at_fault", retries, MR);
        pll_lock = 1'b1;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (pll_reset !== 1'b1 || rst_out !== 1'b1 || fault !== 1'b1 || ready !== 1'b0) bad++;
        end
        check("t3_fault_terminal", bad, 0);
        do_reset();
        check("t3_reset_clears_fault", fault, 0);
        check("t3_reset_clears_retries", retries, 0);

        // Phase step with settle and ack
        wait_reset_fall(n);
        lock_after($urandom_range(0, 40), n);
        check("t4_lock_latency", n, 2 + LS);
        run_step(4'b0011, -1);

        // Lock loss five cycles into settle
        run_step(4'b0011, 5);

        // Lock loss and ph_req seen on the same edge
        pll_lock = 1'b0;
        tick();
        tick();
        ph_val = 4'b0101;
        ph_req = 1'b1;
        tick();
        check("t6_ready_low", ready, 0);
        check("t6_rst_out_high", rst_out, 1);
        check("t6_pll_reset_high", pll_reset, 1);
        check("t6_psda_unchanged", psda, 4'b0011);
        pulses = 0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (ph_ack === 1'b1 || ph_nak === 1'b1) pulses++;
            if (psda !== 4'b0011) bad++;
            tick();
        end
        check("t6_no_ack_nak", pulses, 0);
        check("t6_req_ignored_not_ready", bad, 0);
        ph_req = 1'b0;
        lock_after($urandom_range(0, 20), n);
        check("t6_relock_latency", n, 2 + LS);

        // Randomized steps against the model
        for (int k = 0; k < 10; k++) begin
            v = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) run_step(v, $urandom_range(0, 12));
            else run_step(v, -1);
        end

        // Reset in the middle of settle
        v = 4'($urandom_range(0, 15));
        ph_val = v;
        ph_req = 1'b1;
        tick();
        repeat (5) tick();
        reset = 1'b1;
        tick();
        check("rs_psda_init", psda, P_INIT);
        check("rs_ready", ready, 0);
        check("rs_rst_out", rst_out, 1);
        check("rs_pll_reset", pll_reset, 1);
        reset    = 1'b0;
        ph_req   = 1'b0;
        pll_lock = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (ph_ack === 1'b1 || ph_nak === 1'b1) pulses++;
            tick();
        end
        check("rs_no_ack_nak", pulses, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pll_lock_phase_ctrl.md
Name: pll_lock_phase_ctrl

Overview:
- Supervisor/controller for one Gowin rPLL instance, running in the PLL reference clock domain (27 MHz board clock).
- Sequences the PLL RESET pin, qualifies the asynchronous LOCK output and produces a glitch-free downstream reset.
- Retries failed locks and drives PSDA dynamic phase steps through a req/ack handshake with a post-step settle window, so video/SDRAM capture phase can be tuned at run time. The PLL is instantiated with DYN_DA_EN enabled.

Parameters:
- PHASE_BITS, 4, width of PSDA phase code (16 steps of 22.5 deg).
- PHASE_INIT, 4'b1000, PSDA value after reset.
- RESET_CYCLES, 16, cycles pll_reset is held high per attempt.
- LOCK_STABLE, 256, consecutive synchronized-lock cycles required before release.
- LOCK_TIMEOUT, 65536, cycles allowed in WAIT_LOCK per attempt.
- SETTLE_CYCLES, 64, cycles waited after a PSDA change.
- MAX_RETRY, 3, failed attempts before FAULT.

Ports:
- clkin  in  1  controller clock (PLL reference clock).
- reset  in  1  synchronous active-high reset.
- pll_lock  in  1  raw rPLL LOCK, asynchronous.
- pll_reset  out  1  to rPLL RESET.
- psda  out  PHASE_BITS  to rPLL PSDA.
- rst_out  out  1  active-high reset for the PLL output domains.
- ready  out  1  PLL locked, no phase step in progress.
- fault  out  1  lock retries exhausted.
- retries  out  2  failed-attempt count of the current incident.
- ph_req  in  1  phase-step request (level, sampled when ready=1).
- ph_val  in  PHASE_BITS  requested PSDA code.
- ph_ack  out  1  one-cycle pulse: step applied and settled with lock held.
- ph_nak  out  1  one-cycle pulse: lock lost during settle.

Behaviour:
- One clock, clkin. reset is synchronous and active-high. All outputs are registered.
- Reset values: state=RST_PLL, pll_reset=1, rst_out=1, psda=PHASE_INIT, ready=0, fault=0, retries=0, ph_ack=0, ph_nak=0, counter=0.
- pll_lock passes through a 2-flop synchronizer to give lock_s. lock_s lags pll_lock by 2 cycles.
- RST_PLL:
  - pll_reset=1, rst_out=1.
  - After RESET_CYCLES cycles: counter:=0, go to WAIT_LOCK, pll_reset=0 from the next cycle.
- WAIT_LOCK:
  - Count cycles. Keep a stable counter that increments while lock_s=1 and clears to 0 when lock_s=0.
  - Stable counter reaches LOCK_STABLE: go to LOCKED.
  - Else, counter reaches LOCK_TIMEOUT-1: retries+1. If the new value equals MAX_RETRY, go to FAULT; otherwise go to RST_PLL.
  - If stable and timeout occur in the same cycle, LOCKED wins.
- LOCKED:
  - ready=1, rst_out=0. rst_out falls on the same edge ready rises.
  - lock_s=0 has priority over ph_req: go to RST_PLL, rst_out=1 and ready=0 on the next edge, retries:=0 (new incident).
  - Otherwise, ph_req=1: psda:=ph_val, counter:=0, ready:=0, go to SETTLE.
  - ph_val equal to the current psda is still a full step (settle and ack).
- SETTLE:
  - rst_out stays 0, ready=0. ph_req is ignored.
  - lock_s=0 at any cycle: one-cycle ph_nak, go to RST_PLL. psda retains the new value.
  - After SETTLE_CYCLES cycles with lock held: one-cycle ph_ack, ready=1, return to LOCKED.
  - ph_ack and the ready rise occur on the same edge.
- FAULT:
  - pll_reset=1, rst_out=1, fault=1, ready=0.
  - Terminal; left only by reset.
- ph_req while ready=0 is ignored. Requesters hold ph_req until they see ph_ack or ph_nak.
- Reset asserted mid-SETTLE or mid-WAIT_LOCK: reset values on the next edge. psda returns to PHASE_INIT and no ack/nak is emitted.
- Counters are sized $clog2 of the largest of RESET_CYCLES, LOCK_TIMEOUT and SETTLE_CYCLES, plus 1. No wrap-around is reachable.

Test Plan:
Bench parameters: RESET_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=64, SETTLE_CYCLES=16, MAX_RETRY=3.
1. Normal lock: release reset, raise pll_lock 10 cycles after pll_reset falls and hold it -> pll_reset high exactly 4 cycles; rst_out falls and ready rises 10 cycles (2 sync + 8 stable) after pll_lock rises; psda=4'b1000.
2. Glitchy lock: pll_lock high 5 cycles, low 1, then high -> stable count restarts; release occurs 10 cycles after the final rise, never earlier.
3. Timeout/fault: pll_lock held 0 -> three RST_PLL/WAIT_LOCK attempts, retries 1, 2, then fault=1 and pll_reset=1 permanently; reset clears fault and retries.
4. Phase step: when locked, ph_req=1, ph_val=4'b0011 -> psda=0011 the next cycle; ready low 16 cycles; single ph_ack; rst_out stays 0 throughout.
5. Lock loss in settle: drop pll_lock 5 cycles into SETTLE -> ph_nak pulse 2-3 cycles later, rst_out=1, pll_reset=1 for 4 cycles, psda stays 0011, relock releases normally with retries=0.
6. Simultaneous ph_req and lock loss in LOCKED -> go to RST_PLL, psda unchanged, neither ph_ack nor ph_nak asserted.
